imem_fetch_port: RTL and testbench
==================================

// Module: imem_fetch_port
// PURPOSE
//  Core-side initiator for the shared instruction-memory controller; one instance per core.
//  Accepts a fetch request (PC) from its core and drives address/read-enable toward the controller.
//  Waits for its own acq bit, then samples byte data from the controller's Dq after a fixed read latency.
//  Assembles INSTR_BYTES consecutive bytes into one instruction word and hands it to the core with a valid pulse.
// PARAMETERS
//  CORE_ID      0    index of this core's bit in mem_acq[]
//  NCORES       2    width of the controller acq bus
//  INSTR_BYTES  2    bytes per instruction word (1..4), little-endian assembly
//  RD_LAT       1    cycles from acq-high sample to valid byte on mem_dq[7:0] (>=1)
//  TIMEOUT      255  max cycles waiting for acq before err_timeout (>=1, 8-bit counter)
// PORTS
//  clk          in   1                  single clock, rising edge
//  rst          in   1                  asynchronous, active-high reset
//  fetch_req    in   1                  core requests instruction at fetch_pc (level, sampled in IDLE)
//  fetch_pc     in   32                 byte address of instruction
//  fetch_flush  in   1                  abort current fetch (branch/redirect)
//  fetch_valid  out  1                  one-cycle pulse: instr holds complete word
//  instr        out  8*INSTR_BYTES      assembled instruction, byte0 at [7:0]
//  busy         out  1                  high in any state except IDLE
//  err_timeout  out  1                  sticky; set when acq not seen within TIMEOUT cycles
//  mem_rden     out  1                  read request toward controller (this core's rden bit)
//  mem_address  out  32                 byte address toward controller; only [7:0] significant
//  mem_acq      in   NCORES             controller grant vector
//  mem_dq       in   32                 controller read data; byte in [7:0]
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; all outputs 0; byte index, latency and timeout counters 0;
//   err_timeout cleared only by rst.
//  States: IDLE -> REQ -> WAIT -> (REQ for next byte | DONE) -> IDLE.
//  IDLE: busy=0, mem_rden=0. fetch_req=1 & fetch_flush=0 -> latch addr_base=fetch_pc,
//   byte_idx=0 -> REQ.
//  REQ: mem_rden=1, mem_address=addr_base+byte_idx (32-bit wrap; low 8 bits wrap 0xFF->0x00).
//   Address stable for whole REQ/WAIT. mem_acq[CORE_ID]=1 sampled -> WAIT, lat_cnt=0,
//   to_cnt cleared. Else to_cnt++; to_cnt==TIMEOUT-1 -> set err_timeout, -> IDLE,
//   no fetch_valid. Other acq bits ignored (broadcast grants to other cores are legal).
//  WAIT: mem_rden=0, lat_cnt++ each cycle; on lat_cnt==RD_LAT-1 capture
//   mem_dq[7:0] into instr[8*byte_idx +: 8].
//   If byte_idx==INSTR_BYTES-1 -> DONE, else byte_idx++ -> REQ.
//   acq deassertion during WAIT is ignored.
//  DONE: fetch_valid=1 for exactly one cycle; instr held until next capture -> IDLE.
//  Minimum latency, acq immediate: fetch_req sample to fetch_valid = 1 + INSTR_BYTES*(1+RD_LAT) cycles.
//  fetch_flush=1 in any state: -> IDLE next edge, mem_rden=0, no fetch_valid,
//   partial instr bytes not presented. Flush wins over a simultaneous DONE transition.
//   fetch_req in the same cycle as flush is ignored; it is re-sampled in IDLE.
//  fetch_req held high after DONE: new fetch starts at the next IDLE cycle with the current fetch_pc.
//  fetch_pc changes mid-fetch have no effect; addr_base is latched.
//  rst mid-operation: immediate return to IDLE, outputs 0, no partial fetch_valid.
//  mem_dq[31:8] unused.
// STRUCTURE
//  Shared package / header (imem_pkg): state encodings IDLE/REQ/WAIT/DONE;
//   IMEM_ADDR_W=8; IMEM_DATA_W=8. The controller uses the same constants.
//  Single module, no sub-modules; counters are inline.
// TESTING
//  Bench models the controller: acq after programmable delay, data = addr^8'hA5 valid RD_LAT after grant.
//  1 Basic: pc=0x10, acq immediate, INSTR_BYTES=2, RD_LAT=1 -> addresses 0x10,0x11;
//    instr=16'hB4B5; fetch_valid on cycle 5 after req.
//  2 Grant stall: acq delayed 7 cycles per byte -> mem_rden/mem_address stable throughout;
//    instr correct; err_timeout=0.
//  3 Timeout: acq never asserted, TIMEOUT=16 -> err_timeout=1 on cycle 16; busy=0 after;
//    no fetch_valid.
//  4 Flush: assert fetch_flush during WAIT of byte0 -> IDLE next edge, no fetch_valid;
//    new req pc=0x20 yields instr from 0x20/0x21.
//  5 Wrap + foreign grant: pc=0xFF, acq=2'b10 for 3 cycles then 2'b01 -> ignores
//    foreign grant; addresses 0xFF then 0x100 (low byte 0x00).
//  6 Async reset asserted in REQ between edges -> all outputs 0 immediately; resumes
//    cleanly after release.

Source files
------------

// File: rtl/imem_pkg.sv
// Constants and state encoding shared by the instruction-memory fetch ports
// and the memory controller they talk to.
package imem_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } imem_state_e;

endpackage

// File: rtl/imem_fetch_port.sv
// Core-side fetch initiator: requests INSTR_BYTES bytes one at a time from the
// shared instruction-memory controller and presents the assembled word.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int CORE_ID     = 0,
  parameter int NCORES      = 2,
  parameter int INSTR_BYTES = 2,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [31:0]              fetch_pc,
  input  logic                     fetch_flush,
  output logic                     fetch_valid,
  output logic [8*INSTR_BYTES-1:0] instr,
  output logic                     busy,
  output logic                     err_timeout,
  output logic                     mem_rden,
  output logic [31:0]              mem_address,
  input  logic [NCORES-1:0]        mem_acq,
  input  logic [31:0]              mem_dq
);

  localparam logic [1:0] LAST_IDX = 2'(INSTR_BYTES - 1);
  localparam logic [7:0] LAT_LAST = 8'(RD_LAT - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  imem_state_e              state;
  imem_state_e              state_nxt;
  logic [31:0]              addr_base;
  logic [1:0]               byte_idx;
  logic [7:0]               lat_cnt;
  logic [7:0]               to_cnt;
  logic [8*INSTR_BYTES-1:0] instr_q;
  logic                     err_q;
  logic                     acq_own;
  logic                     lat_done;
  logic                     last_byte;
  logic                     unused_in;

  assign acq_own   = mem_acq[CORE_ID];
  assign lat_done  = (lat_cnt == LAT_LAST);
  assign last_byte = (byte_idx == LAST_IDX);
  assign unused_in = ^{mem_dq[31:IMEM_DATA_W], mem_acq};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush overrides every transition, including the one into DONE.
  always_comb begin
    state_nxt   = state;
    mem_rden    = 1'b0;
    fetch_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fetch_req) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        mem_rden = 1'b1;
        if (acq_own) state_nxt = ST_WAIT;
        else if (to_cnt == TO_LAST) state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        if (lat_done) state_nxt = last_byte ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        fetch_valid = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (fetch_flush) begin
      state_nxt   = ST_IDLE;
      mem_rden    = 1'b0;
      fetch_valid = 1'b0;
    end
  end

  // Address, byte index, counters and the assembled word; a flushed cycle changes none of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_base <= '0;
      byte_idx  <= '0;
      lat_cnt   <= '0;
      to_cnt    <= '0;
      instr_q   <= '0;
      err_q     <= 1'b0;
    end else if (!fetch_flush) begin
      case (state)
        ST_IDLE: begin
          if (fetch_req) begin
            addr_base <= fetch_pc;
            byte_idx  <= '0;
            to_cnt    <= '0;
          end
        end
        ST_REQ: begin
          if (acq_own) begin
            lat_cnt <= '0;
            to_cnt  <= '0;
          end else if (to_cnt == TO_LAST) begin
            err_q  <= 1'b1;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt + 8'd1;
          if (lat_done) begin
            for (int i = 0; i < INSTR_BYTES; i++) begin
              if (byte_idx == 2'(i)) instr_q[8*i +: 8] <= mem_dq[IMEM_DATA_W-1:0];
            end
            if (!last_byte) byte_idx <= byte_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != ST_IDLE);
  assign mem_address = (state == ST_REQ || state == ST_WAIT) ? addr_base + {30'd0, byte_idx} : '0;
  assign instr       = instr_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port: a behavioural controller model (programmable grant
// delay, data = address ^ 8'hA5 one cycle after the grant) plus a scoreboard.
module tb_imem_fetch_port;

  localparam int CORE_ID     = 0;
  localparam int NCORES      = 2;
  localparam int INSTR_BYTES = 2;
  localparam int RD_LAT      = 1;
  localparam int TIMEOUT     = 16;

  logic                     clk;
  logic                     rst;
  logic                     fetch_req;
  logic [31:0]              fetch_pc;
  logic                     fetch_flush;
  logic                     fetch_valid;
  logic [8*INSTR_BYTES-1:0] instr;
  logic                     busy;
  logic                     err_timeout;
  logic                     mem_rden;
  logic [31:0]              mem_address;
  logic [NCORES-1:0]        mem_acq;
  logic [31:0]              mem_dq;

  int n_checks = 0;
  int n_fail   = 0;

  // Controller model and scoreboard state
  int          acq_delay  = 0;
  bit          acq_never  = 0;
  bit          foreign_en = 0;
  int          wait_cnt   = 0;
  int          rden_cnt   = 0;
  int          byte_no    = 0;
  bit          pending    = 0;
  logic [7:0]  pend_addr;
  logic [31:0] cur_pc     = '0;
  logic [31:0] rnd;
  logic        exp_err    = 1'b0;
  logic [31:0] grant_log[$];
  logic [8*INSTR_BYTES-1:0] exp_q[$];

  imem_fetch_port #(
    .CORE_ID    (CORE_ID),
    .NCORES     (NCORES),
    .INSTR_BYTES(INSTR_BYTES),
    .RD_LAT     (RD_LAT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_pc   (fetch_pc),
    .fetch_flush(fetch_flush),
    .fetch_valid(fetch_valid),
    .instr      (instr),
    .busy       (busy),
    .err_timeout(err_timeout),
    .mem_rden   (mem_rden),
    .mem_address(mem_address),
    .mem_acq    (mem_acq),
    .mem_dq     (mem_dq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8*INSTR_BYTES-1:0] model_word(input logic [31:0] pc);
    logic [8*INSTR_BYTES-1:0] w;
    logic [31:0] a;
    w = '0;
    for (int i = 0; i < INSTR_BYTES; i++) begin
      a = pc + 32'(i);
      w[8*i +: 8] = a[7:0] ^ 8'hA5;
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Launches one fetch: req pulse sampled at the next edge; returns one negedge later.
  task automatic applyStimulus(input logic [31:0] pc, input bit expect_word);
    @(negedge clk);
    fetch_pc  = pc;
    fetch_req = 1'b1;
    cur_pc    = pc;
    byte_no   = 0;
    wait_cnt  = 0;
    rden_cnt  = 0;
    grant_log.delete();
    if (expect_word) exp_q.push_back(model_word(pc));
    @(negedge clk);
    fetch_req = 1'b0;
    fetch_pc  = $urandom;
  endtask

  task automatic waitValid(input int bound, output int cyc);
    cyc = 1;
    while (!fetch_valid && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    if (!fetch_valid) checkOutput("valid_seen", 32'(fetch_valid), 32'd1);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Controller model: decides grants mid-cycle and returns data one cycle after a grant.
  always begin
    @(negedge clk);
    #1;
    rnd = $urandom;
    if (rst) begin
      mem_acq = '0;
      mem_dq  = rnd;
      pending = 0;
    end else begin
      if (pending) begin
        mem_dq = {rnd[31:8], pend_addr ^ 8'hA5};
        byte_no++;
        pending = 0;
      end else begin
        mem_dq = rnd;
      end
      if (mem_rden) begin
        rden_cnt++;
        if (!acq_never && wait_cnt >= acq_delay) begin
          mem_acq   = 2'b01;
          pending   = 1;
          pend_addr = mem_address[7:0];
          grant_log.push_back(mem_address);
          wait_cnt  = 0;
        end else begin
          mem_acq = foreign_en ? 2'b10 : 2'b00;
          wait_cnt++;
        end
      end else begin
        mem_acq = '0;
      end
    end
  end

  // Scoreboard compare, every cycle, after stimulus and controller have settled.
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (mem_rden) begin
        checkOutput("rden_address", mem_address, cur_pc + 32'(byte_no));
        checkOutput("rden_busy", 32'(busy), 32'd1);
      end
      if (fetch_valid) begin
        if (exp_q.size() == 0) checkOutput("valid_expected", 32'(exp_q.size() != 0), 32'd1);
        else checkOutput("instr_model", 32'(instr), 32'(exp_q.pop_front()));
      end
      checkOutput("err_timeout", 32'(err_timeout), 32'(exp_err));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    rst         = 1'b1;
    fetch_req   = 1'b0;
    fetch_pc    = '0;
    fetch_flush = 1'b0;
    mem_acq     = '0;
    mem_dq      = '0;
    #1;
    checkOutput("rst_valid", 32'(fetch_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rden", 32'(mem_rden), 32'd0);
    checkOutput("rst_addr", mem_address, 32'd0);
    checkOutput("rst_instr", 32'(instr), 32'd0);
    checkOutput("rst_err", 32'(err_timeout), 32'd0);
    idleCycles(3);
    rst = 1'b0;
    idleCycles(2);

    $display("[TB] basic fetch");
    applyStimulus(32'h10, 1);
    waitValid(60, cyc);
    checkOutput("t1_latency", 32'(cyc), 32'd5);
    checkOutput("t1_instr", 32'(instr), 32'h0000B4B5);
    checkOutput("t1_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      checkOutput("t1_addr0", grant_log[0], 32'h10);
      checkOutput("t1_addr1", grant_log[1], 32'h11);
    end
    idleCycles(3);

    $display("[TB] grant stall");
    acq_delay = 7;
    applyStimulus(32'h80, 1);
    waitValid(60, cyc);
    checkOutput("t2_latency", 32'(cyc), 32'd19);
    checkOutput("t2_instr", 32'(instr), 32'h00002425);
    checkOutput("t2_rden_cycles", 32'(rden_cnt), 32'd16);
    checkOutput("t2_err", 32'(err_timeout), 32'd0);
    acq_delay = 0;
    idleCycles(3);

    $display("[TB] timeout");
    acq_never = 1;
    applyStimulus(32'h50, 0);
    cyc = 1;
    while (!err_timeout && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (err_timeout) exp_err = 1'b1;
    checkOutput("t3_err_set", 32'(err_timeout), 32'd1);
    checkOutput("t3_timeout_edge", 32'(cyc - 1), 32'd16);
    checkOutput("t3_rden_cycles", 32'(rden_cnt), 32'd16);
    checkOutput("t3_busy_after", 32'(busy), 32'd0);
    acq_never = 0;
    idleCycles(4);

    $display("[TB] flush during wait");
    applyStimulus(32'h30, 0);
    @(negedge clk);
    checkOutput("t4_in_wait_busy", 32'(busy), 32'd1);
    checkOutput("t4_in_wait_rden", 32'(mem_rden), 32'd0);
    fetch_flush = 1'b1;
    @(negedge clk);
    fetch_flush = 1'b0;
    checkOutput("t4_flush_idle", 32'(busy), 32'd0);
    idleCycles(6);
    applyStimulus(32'h20, 1);
    waitValid(60, cyc);
    checkOutput("t4_instr", 32'(instr), 32'h00008485);
    idleCycles(3);

    $display("[TB] address wrap and foreign grant");
    acq_delay  = 3;
    foreign_en = 1;
    applyStimulus(32'hFF, 1);
    waitValid(60, cyc);
    checkOutput("t5_latency", 32'(cyc), 32'd11);
    checkOutput("t5_instr", 32'(instr), 32'h0000A55A);
    checkOutput("t5_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      checkOutput("t5_addr0", grant_log[0], 32'hFF);
      checkOutput("t5_addr1", grant_log[1], 32'h100);
    end
    acq_delay  = 0;
    foreign_en = 0;
    idleCycles(3);

    $display("[TB] async reset in REQ");
    acq_never = 1;
    applyStimulus(32'h60, 0);
    checkOutput("t6_pre_rden", 32'(mem_rden), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    exp_err = 1'b0;
    checkOutput("t6_rst_rden", 32'(mem_rden), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_addr", mem_address, 32'd0);
    checkOutput("t6_rst_instr", 32'(instr), 32'd0);
    checkOutput("t6_rst_err", 32'(err_timeout), 32'd0);
    checkOutput("t6_rst_valid", 32'(fetch_valid), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    acq_never = 0;
    idleCycles(2);
    applyStimulus(32'h40, 1);
    waitValid(60, cyc);
    checkOutput("t6_latency", 32'(cyc), 32'd5);
    checkOutput("t6_instr", 32'(instr), 32'h0000E4E5);
    idleCycles(4);

    checkOutput("leftover_words", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
